// File: rtl/dsp48a1_p_collector.sv
// dsp48a1_p_collector
//
// Result-side companion to the DSP48A1 slice pipeline registers. It tracks
// which operand sets were issued into the slice pipeline. It captures each
// matching P result into a small FIFO and presents the results on a
// ready/valid output.
//
// If a result emerges while the FIFO is full and nothing is being popped,
// the shared clock-enable (ce) goes low. This freezes the slice pipeline
// together with the valid tracker below, so no result is ever lost.
//
// Optional feature: define DSP48A1_COLLECT_CARRY_EN to add the ports
// carry_in and m_carry. The slice CARRYOUT is then stored next to P in
// every FIFO entry.
//
// Parameters:
//   WIDTH   - width of P and m_data (default 48)
//   LATENCY - number of enabled register stages from issue to valid P (0..8)
//   DEPTH   - FIFO entries, power of two (2..16)
//
// Ports:
//   clk      in   single clock, rising edge
//   rst      in   asynchronous active-high reset
//   s_valid  in   operand set presented to the slice
//   s_ready  out  equals ce; an issue happens on s_valid && s_ready
//   ce       out  clock-enable to every slice pipeline register
//   p_in     in   P output of the slice
//   carry_in in   slice CARRYOUT (carry build only)
//   m_data   out  head-of-FIFO result
//   m_carry  out  carry of the head entry (carry build only)
//   m_valid  out  m_data holds a result
//   m_ready  in   downstream accepts; pop on m_valid && m_ready
//   count    out  FIFO occupancy
module dsp48a1_p_collector #(
    parameter int WIDTH   = 48,
    parameter int LATENCY = 3,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic                       ce,
    input  logic [WIDTH-1:0]           p_in,
`ifdef DSP48A1_COLLECT_CARRY_EN
    input  logic                       carry_in,
    output logic                       m_carry,
`endif
    output logic [WIDTH-1:0]           m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
`ifdef DSP48A1_COLLECT_CARRY_EN
    localparam int EW = WIDTH + 1;
`else
    localparam int EW = WIDTH;
`endif

    logic          emerge;
    logic          issue;
    logic          push;
    logic          pop;
    logic          full;
    logic [EW-1:0] entry_in;

    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [EW-1:0] mem_reg [DEPTH];

`ifdef DSP48A1_COLLECT_CARRY_EN
    assign entry_in = {carry_in, p_in};
`else
    assign entry_in = p_in;
`endif

    assign issue   = s_valid && ce;
    assign pop     = m_valid && m_ready;
    assign full    = (count_reg == CW'(DEPTH));
    // m_ready reaches ce combinationally. A pop in the same cycle frees
    // the slot that the emerging result needs.
    assign ce      = !(emerge && full && !pop);
    assign s_ready = ce;
    assign push    = emerge && ce;

    // Valid tracker. It shifts only when ce is high, so it stays aligned
    // with the slice registers it shadows.
    generate
        if (LATENCY > 0) begin : g_track
            logic [LATENCY-1:0] vld_reg;
            for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        vld_reg[gi] <= 1'b0;
                    end else if (ce) begin
                        if (gi == 0) begin
                            vld_reg[gi] <= issue;
                        end else begin
                            vld_reg[gi] <= vld_reg[(gi > 0) ? gi - 1 : 0];
                        end
                    end
                end
            end
            assign emerge = vld_reg[LATENCY-1];
        end else begin : g_notrack
            // With no pipeline stages, the result is on p_in in the same
            // cycle as the operands.
            assign emerge = s_valid;
        end
    endgenerate

    // FIFO storage. It is cleared on reset so that m_data reads as zero.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mem_reg[gi] <= '0;
                end else if (push && (wr_ptr_reg == PW'(gi))) begin
                    mem_reg[gi] <= entry_in;
                end
            end
        end
    endgenerate

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign m_data  = mem_reg[rd_ptr_reg][WIDTH-1:0];
`ifdef DSP48A1_COLLECT_CARRY_EN
    assign m_carry = mem_reg[rd_ptr_reg][EW-1];
`endif
    assign m_valid = (count_reg != '0);
    assign count   = count_reg;

endmodule

// File: tb/tb_dsp48a1_p_collector.sv
// Bench for dsp48a1_p_collector. It has two instances: one with
// LATENCY=3, DEPTH=4 and one with LATENCY=0, DEPTH=4.
// A behavioural model of the slice pipeline produces p_in from the issued
// operands. Issued operands are queued as expected results, popped results
// are queued as observed results, and each test compares the two queues.
module tb_dsp48a1_p_collector;

    localparam int W = 48;
    localparam int L = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid, s_ready, ce, m_valid, m_ready;
    logic [W-1:0] s_data, p_in, m_data;
    logic [2:0]   count;
    logic         s_valid0, s_ready0, ce0, m_valid0, m_ready0;
    logic [W-1:0] s_data0, m_data0;
    logic [2:0]   count0;
    logic [W-1:0] pipe0, pipe1, pipe2;
`ifdef DSP48A1_COLLECT_CARRY_EN
    logic         c_in, m_carry, cpipe0, cpipe1, cpipe2;
    logic         carry_in0, m_carry0;
    bit           gotc_q[$];
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int ecnt    = 0;
    int stall_cnt = 0;
    logic [W-1:0] exp_q[$], got_q[$], exp0_q[$], got0_q[$];
    int           iss_t_q[$], pop_t_q[$];

    always #5 clk = ~clk;

    // Model of the slice registers. They advance only when ce is high.
    always @(posedge clk) begin
        if (ce) begin
            pipe0 <= s_data;
            pipe1 <= pipe0;
            pipe2 <= pipe1;
`ifdef DSP48A1_COLLECT_CARRY_EN
            cpipe0 <= c_in;
            cpipe1 <= cpipe0;
            cpipe2 <= cpipe1;
`endif
        end
    end
    assign p_in = pipe2;

    dsp48a1_p_collector #(.WIDTH(W), .LATENCY(L), .DEPTH(4)) u_dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .ce(ce),
        .p_in(p_in),
`ifdef DSP48A1_COLLECT_CARRY_EN
        .carry_in(cpipe2), .m_carry(m_carry),
`endif
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .count(count)
    );

`ifdef DSP48A1_COLLECT_CARRY_EN
    assign carry_in0 = 1'b0;
`endif
    dsp48a1_p_collector #(.WIDTH(W), .LATENCY(0), .DEPTH(4)) u_dut0 (
        .clk(clk), .rst(rst), .s_valid(s_valid0), .s_ready(s_ready0), .ce(ce0),
        .p_in(s_data0),
`ifdef DSP48A1_COLLECT_CARRY_EN
        .carry_in(carry_in0), .m_carry(m_carry0),
`endif
        .m_data(m_data0), .m_valid(m_valid0), .m_ready(m_ready0), .count(count0)
    );

    // Advance one clock. Issues and pops that happen at this edge are
    // recorded first.
    task automatic cycle();
        #1;
        if (s_valid && s_ready) begin
            exp_q.push_back(s_data);
            iss_t_q.push_back(ecnt);
        end
        if (m_valid && m_ready) begin
            got_q.push_back(m_data);
            pop_t_q.push_back(ecnt);
`ifdef DSP48A1_COLLECT_CARRY_EN
            gotc_q.push_back(m_carry);
`endif
        end
        if (!ce) stall_cnt++;
        if (s_valid0 && s_ready0) exp0_q.push_back(s_data0);
        if (m_valid0 && m_ready0) got0_q.push_back(m_data0);
        @(posedge clk);
        #1;
        ecnt++;
    endtask

    task automatic clear_queues();
        exp_q.delete(); got_q.delete(); exp0_q.delete(); got0_q.delete();
        iss_t_q.delete(); pop_t_q.delete();
`ifdef DSP48A1_COLLECT_CARRY_EN
        gotc_q.delete();
`endif
        stall_cnt = 0;
    endtask

    task automatic test_reset();
        int n;
        #1;
        n_tests++;
        if (m_valid !== 1'b0 || count !== 3'd0 || ce !== 1'b1 || m_data !== '0) begin
            n_fail++;
            $display("FAIL reset_state: m_valid=%b count=%0d ce=%b m_data=%h, required 0 0 1 0",
                     m_valid, count, ce, m_data);
        end
        @(posedge clk); #1; rst = 1'b0;
        // Put 2 results in the FIFO, then reset in the middle of the stream.
        m_ready = 1'b0;
        s_data = 48'h11; s_valid = 1'b1; cycle();
        s_data = 48'h22; cycle();
        s_valid = 1'b0;
        n = 0;
        while (count != 3'd2 && n < 20) begin cycle(); n++; end
        n_tests++;
        if (count !== 3'd2) begin
            n_fail++;
            $display("FAIL reset_prefill: count=%0d required 2", count);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (m_valid !== 1'b0 || count !== 3'd0 || ce !== 1'b1 || m_data !== '0) begin
            n_fail++;
            $display("FAIL reset_midstream: m_valid=%b count=%0d ce=%b m_data=%h, required 0 0 1 0",
                     m_valid, count, ce, m_data);
        end
        @(posedge clk); #1; rst = 1'b0;
        clear_queues();
        // Issue one operand after reset and measure how long m_valid takes.
        s_data = 48'h000000000005; s_valid = 1'b1; cycle();
        s_valid = 1'b0;
        n = 1;
        while (!m_valid && n < 20) begin cycle(); n++; end
        n_tests++;
        if (n != L + 1 || m_data !== 48'h5) begin
            n_fail++;
            $display("FAIL reset_reissue: latency=%0d data=%h, required %0d 5", n, m_data, L + 1);
        end
        m_ready = 1'b1; cycle(); m_ready = 1'b0;
        $display("[TB] test_reset done");
    endtask

    task automatic test_stream();
        int n;
        clear_queues();
        m_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_data = W'(i); s_valid = 1'b1; cycle();
        end
        s_valid = 1'b0;
        n = 0;
        while (got_q.size() < 10 && n < 40) begin cycle(); n++; end
        n_tests++;
        if (got_q.size() != 10 || stall_cnt != 0) begin
            n_fail++;
            $display("FAIL stream_count: got=%0d stalls=%0d, required 10 0", got_q.size(), stall_cnt);
        end
        for (int i = 0; i < got_q.size() && i < iss_t_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== W'(i) || pop_t_q[i] != iss_t_q[i] + L + 1) begin
                n_fail++;
                $display("FAIL stream_item%0d: data=%h latency=%0d, required %h %0d",
                         i, got_q[i], pop_t_q[i] - iss_t_q[i], W'(i), L + 1);
            end
            $display("[TB] stream result %0d data=%h", i, got_q[i]);
        end
        m_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        clear_queues();
        m_ready = 1'b0;
        for (int c = 0; c < 14; c++) begin
            s_data  = W'(100 + exp_q.size());
            s_valid = (exp_q.size() < 8);
            cycle();
        end
        s_data  = W'(100 + exp_q.size());
        s_valid = (exp_q.size() < 8);
        #1;
        n_tests++;
        if (count !== 3'd4 || exp_q.size() != 7 || ce !== 1'b0 || s_ready !== 1'b0 || stall_cnt == 0) begin
            n_fail++;
            $display("FAIL backpressure_stall: count=%0d issued=%0d ce=%b s_ready=%b stalls=%0d, required 4 7 0 0 >0",
                     count, exp_q.size(), ce, s_ready, stall_cnt);
        end
        $display("[TB] backpressure count=%0d issued=%0d ce=%b", count, exp_q.size(), ce);
    endtask

    task automatic test_full_push_pop();
        int n;
        m_ready = 1'b1;
        #1;
        n_tests++;
        if (ce !== 1'b1 || s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL full_pushpop_ce: ce=%b s_ready=%b required 1 1", ce, s_ready);
        end
        cycle();
        n_tests++;
        if (count !== 3'd4) begin
            n_fail++;
            $display("FAIL full_pushpop_count: count=%0d required 4", count);
        end
        n = 0;
        while (got_q.size() < 8 && n < 40) begin
            s_data  = W'(100 + exp_q.size());
            s_valid = (exp_q.size() < 8);
            cycle();
            n++;
        end
        s_valid = 1'b0;
        n_tests++;
        if (got_q.size() != 8 || exp_q.size() != 8) begin
            n_fail++;
            $display("FAIL backpressure_total: got=%0d issued=%0d required 8 8", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== W'(100 + i)) begin
                n_fail++;
                $display("FAIL backpressure_item%0d: data=%h required %h", i, got_q[i], W'(100 + i));
            end
            $display("[TB] backpressure result %0d data=%h", i, got_q[i]);
        end
        m_ready = 1'b0;
    endtask

    task automatic test_latency0();
        int n;
        clear_queues();
        m_ready0 = 1'b0;
        s_data0 = 48'hABC; s_valid0 = 1'b1; cycle();
        s_valid0 = 1'b0; #1;
        n_tests++;
        if (m_valid0 !== 1'b1 || m_data0 !== 48'hABC || count0 !== 3'd1) begin
            n_fail++;
            $display("FAIL lat0_first: m_valid=%b data=%h count=%0d required 1 abc 1", m_valid0, m_data0, count0);
        end
        for (int i = 1; i < 4; i++) begin
            s_data0 = W'(48'hAB0 + i); s_valid0 = 1'b1; cycle();
        end
        s_data0 = 48'hDEF; #1;
        n_tests++;
        if (count0 !== 3'd4 || s_ready0 !== 1'b0) begin
            n_fail++;
            $display("FAIL lat0_full: count=%0d s_ready=%b required 4 0", count0, s_ready0);
        end
        m_ready0 = 1'b1; #1;
        n_tests++;
        if (s_ready0 !== 1'b1) begin
            n_fail++;
            $display("FAIL lat0_release: s_ready=%b required 1", s_ready0);
        end
        cycle();
        s_valid0 = 1'b0;
        n = 0;
        while (got0_q.size() < 5 && n < 20) begin cycle(); n++; end
        n_tests++;
        if (got0_q.size() != 5 || exp0_q.size() != 5) begin
            n_fail++;
            $display("FAIL lat0_total: got=%0d issued=%0d required 5 5", got0_q.size(), exp0_q.size());
        end
        for (int i = 0; i < got0_q.size() && i < exp0_q.size(); i++) begin
            n_tests++;
            if (got0_q[i] !== exp0_q[i]) begin
                n_fail++;
                $display("FAIL lat0_item%0d: data=%h required %h", i, got0_q[i], exp0_q[i]);
            end
            $display("[TB] lat0 result %0d data=%h", i, got0_q[i]);
        end
        m_ready0 = 1'b0;
    endtask

`ifdef DSP48A1_COLLECT_CARRY_EN
    task automatic test_carry();
        int n;
        logic [W-1:0] vals [3];
        vals[0] = 48'hFFFE; vals[1] = 48'hFFFF; vals[2] = 48'h10000;
        clear_queues();
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_data = vals[i]; c_in = (vals[i] == 48'hFFFF); s_valid = 1'b1; cycle();
        end
        s_valid = 1'b0; c_in = 1'b0;
        n = 0;
        while (got_q.size() < 3 && n < 20) begin cycle(); n++; end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (i >= got_q.size() || got_q[i] !== vals[i] || gotc_q[i] != (i == 1)) begin
                n_fail++;
                $display("FAIL carry_item%0d: got %0d entries, required data %h carry %0d",
                         i, got_q.size(), vals[i], (i == 1));
            end else begin
                $display("[TB] carry result %0d data=%h carry=%0d", i, got_q[i], gotc_q[i]);
            end
        end
        m_ready = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        s_valid0 = 1'b0; s_data0 = '0; m_ready0 = 1'b0;
`ifdef DSP48A1_COLLECT_CARRY_EN
        c_in = 1'b0;
`endif
        test_reset();
        test_stream();
        test_backpressure();
        test_full_push_pop();
        test_latency0();
`ifdef DSP48A1_COLLECT_CARRY_EN
        test_carry();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
